// File: rtl/cpu_spi_frontend.sv
// CPU SPI word front end: MOSI deserializer with RX skid FIFO into SRAM,
// SRAM read prefetch serialized onto MISO, framing recovered by SCLK idle timeout.
module cpu_spi_frontend #(
    parameter int WIDTH        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    input  logic             sram_hint,
    input  logic             sram_full,
    input  logic             sram_empty,
    output logic             sram_write,
    output logic [WIDTH-1:0] data_to_sram,
    output logic             sram_read,
    input  logic [WIDTH-1:0] data_from_sram,
    output logic [7:0]       overflow_cnt,
    output logic [7:0]       underrun_cnt
);

    localparam int BW = $clog2(WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAP
    } fetch_state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   s_sclk;
    logic                   s_sclk_d;
    logic                   s_mosi;
    logic                   rise;
    logic                   last_bit;
    logic                   timeout;

    logic [BW-1:0]          bit_cnt;
    logic [IW-1:0]          idle_cnt;
    logic [WIDTH-1:0]       rx_shift;
    logic [WIDTH-1:0]       rx_word;

    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-1:0]       tx_cur;
    logic [WIDTH-1:0]       tx_hold;
    logic                   tx_valid;

    logic [WIDTH-1:0]       mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    fetch_state_t           state;
    fetch_state_t           state_nxt;
    logic                   capture;

    // Both pins cross into clk through equal-length chains so MOSI stays
    // aligned with the SCLK rise that samples it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            s_sclk_d  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            s_sclk_d  <= s_sclk;
        end
    end

    assign s_sclk   = sclk_sync[SYNC_STAGES-1];
    assign s_mosi   = mosi_sync[SYNC_STAGES-1];
    assign rise     = s_sclk & ~s_sclk_d;
    assign last_bit = rise & (bit_cnt == BW'(WIDTH - 1));
    assign timeout  = ~rise & (bit_cnt != '0)
                    & (idle_cnt == IW'(IDLE_TIMEOUT - 1));
    assign rx_word  = {rx_shift[WIDTH-2:0], s_mosi};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW])
                      & (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = last_bit & ~fifo_full;
    assign pop        = ~fifo_empty & sram_hint & ~sram_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
            rx_shift <= '0;
        end else begin
            if (rise || bit_cnt == '0 || timeout) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end
            if (last_bit) begin
                bit_cnt  <= '0;
                rx_shift <= rx_word;
            end else if (rise) begin
                bit_cnt  <= bit_cnt + BW'(1);
                rx_shift <= rx_word;
            end else if (timeout) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (last_bit && fifo_full && overflow_cnt != 8'hFF) begin
            overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= rx_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sram_write   <= 1'b0;
            data_to_sram <= '0;
        end else begin
            sram_write <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + (AW+1)'(1);
                data_to_sram <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // tx_cur remembers the word being shifted so an aborted frame can
    // re-present it from its first bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift     <= '0;
            tx_cur       <= '0;
            underrun_cnt <= '0;
        end else if (last_bit) begin
            if (tx_valid) begin
                tx_shift <= tx_hold;
                tx_cur   <= tx_hold;
            end else begin
                tx_shift <= '0;
                tx_cur   <= '0;
                if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end
        end else if (rise) begin
            tx_shift <= tx_shift << 1;
        end else if (timeout) begin
            tx_shift <= tx_cur;
        end
    end

    assign miso = tx_shift[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_hold  <= '0;
            tx_valid <= 1'b0;
        end else if (capture) begin
            tx_hold  <= data_from_sram;
            tx_valid <= 1'b1;
        end else if (last_bit) begin
            tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read data arrives the cycle after the strobe, so it is taken in CAP.
    always_comb begin
        state_nxt = state;
        sram_read = 1'b0;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (~tx_valid & sram_hint & ~sram_empty) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                sram_read = 1'b1;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                capture   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_spi_frontend.sv
// Directed bench for cpu_spi_frontend: SPI master at clk/8 with SRAM port
// stimulus and hand-computed expectations.
module tb_cpu_spi_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        sram_hint;
    logic        sram_full;
    logic        sram_empty;
    logic        sram_write;
    logic [15:0] data_to_sram;
    logic        sram_read;
    logic [15:0] data_from_sram;
    logic [7:0]  overflow_cnt;
    logic [7:0]  underrun_cnt;

    int checks   = 0;
    int failures = 0;
    logic [15:0] wr_q[$];
    int rd_cnt = 0;

    always #5 clk = ~clk;

    cpu_spi_frontend #(
        .WIDTH(16),
        .SYNC_STAGES(2),
        .IDLE_TIMEOUT(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .sram_hint(sram_hint),
        .sram_full(sram_full),
        .sram_empty(sram_empty),
        .sram_write(sram_write),
        .data_to_sram(data_to_sram),
        .sram_read(sram_read),
        .data_from_sram(data_from_sram),
        .overflow_cnt(overflow_cnt),
        .underrun_cnt(underrun_cnt)
    );

    always @(negedge clk) begin
        if (sram_write === 1'b1) wr_q.push_back(data_to_sram);
        if (sram_read === 1'b1) rd_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [15:0] w, input int n,
                            output logic [15:0] r);
        r = '0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            mosi = w[15-i];
            #40;
            sclk = 1'b1;
            r[15-i] = miso;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        wait_clks(3);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        sram_hint = 1'b0;
        sram_full = 1'b0;
        sram_empty = 1'b1;
        data_from_sram = '0;
        wait_clks(2);
        checks++;
        if (miso !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso: got %b want 0", miso);
        end
        checks++;
        if (sram_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_write: got %b want 0", sram_write);
        end
        checks++;
        if (sram_read !== 1'b0) begin
            failures++;
            $display("FAIL reset_read: got %b want 0", sram_read);
        end
        checks++;
        if (data_to_sram !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data: got %h want 0000", data_to_sram);
        end
        checks++;
        if (overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_ovf: got %0d want 0", overflow_cnt);
        end
        checks++;
        if (underrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_unr: got %0d want 0", underrun_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_write();
        logic [15:0] r;
        int base;
        int lat;
        sram_hint = 1'b1;
        sram_full = 1'b0;
        sram_empty = 1'b1;
        base = wr_q.size();
        spi_xfer(16'hA55A, 15, r);
        mosi = 1'b0;
        #40;
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (sram_write === 1'b1 && lat == 0) lat = k;
        end
        sclk = 1'b0;
        wait_clks(4);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL write_latency: got %0d want 4", lat);
        end
        checks++;
        if (wr_q.size() - base !== 1) begin
            failures++;
            $display("FAIL write_count: got %0d want 1", wr_q.size() - base);
        end else begin
            checks++;
            if (wr_q[base] !== 16'hA55A) begin
                failures++;
                $display("FAIL write_data: got %h want a55a", wr_q[base]);
            end
        end
        checks++;
        if (overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL basic_ovf: got %0d want 0", overflow_cnt);
        end
        checks++;
        if (r[15:1] !== 15'h0) begin
            failures++;
            $display("FAIL basic_miso: got %h want 0000", r);
        end
        checks++;
        if (underrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL basic_unr: got %0d want 1", underrun_cnt);
        end
    endtask

    task automatic test_tx_prefetch();
        logic [15:0] r;
        int base;
        int rd0;
        base = wr_q.size();
        rd0 = rd_cnt;
        data_from_sram = 16'h1234;
        sram_empty = 1'b0;
        wait_clks(10);
        checks++;
        if (rd_cnt - rd0 !== 1) begin
            failures++;
            $display("FAIL fetch1: got %0d reads want 1", rd_cnt - rd0);
        end
        spi_xfer(16'h0F0F, 16, r);
        checks++;
        if (r !== 16'h0000) begin
            failures++;
            $display("FAIL tx_word1: got %h want 0000", r);
        end
        wait_clks(10);
        checks++;
        if (rd_cnt - rd0 !== 2) begin
            failures++;
            $display("FAIL fetch2: got %0d reads want 2", rd_cnt - rd0);
        end
        spi_xfer(16'hF00D, 16, r);
        checks++;
        if (r !== 16'h1234) begin
            failures++;
            $display("FAIL tx_word2: got %h want 1234", r);
        end
        wait_clks(10);
        sram_empty = 1'b1;
        checks++;
        if (rd_cnt - rd0 !== 3) begin
            failures++;
            $display("FAIL fetch3: got %0d reads want 3", rd_cnt - rd0);
        end
        checks++;
        if (underrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL tx_unr: got %0d want 1", underrun_cnt);
        end
        checks++;
        if (wr_q.size() - base !== 2) begin
            failures++;
            $display("FAIL tx_writes: got %0d want 2", wr_q.size() - base);
        end else begin
            checks++;
            if (wr_q[base] !== 16'h0F0F || wr_q[base+1] !== 16'hF00D) begin
                failures++;
                $display("FAIL tx_wdata: got %h %h want 0f0f f00d",
                         wr_q[base], wr_q[base+1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] r;
        logic [15:0] words [6];
        int base;
        do_reset();
        sram_hint = 1'b1;
        sram_full = 1'b1;
        sram_empty = 1'b1;
        base = wr_q.size();
        for (int i = 0; i < 6; i++) begin
            words[i] = 16'h1001 * 16'(i + 1);
            spi_xfer(words[i], 16, r);
        end
        wait_clks(6);
        checks++;
        if (wr_q.size() - base !== 0) begin
            failures++;
            $display("FAIL ovf_nowrite: got %0d want 0", wr_q.size() - base);
        end
        checks++;
        if (overflow_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ovf_cnt: got %0d want 2", overflow_cnt);
        end
        sram_full = 1'b0;
        wait_clks(10);
        checks++;
        if (wr_q.size() - base !== 4) begin
            failures++;
            $display("FAIL ovf_drain: got %0d want 4", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_q[base+i] !== words[i]) begin
                    failures++;
                    $display("FAIL ovf_order%0d: got %h want %h",
                             i, wr_q[base+i], words[i]);
                end
            end
        end
    endtask

    task automatic test_idle_abort();
        logic [15:0] r;
        int base;
        do_reset();
        sram_hint = 1'b1;
        sram_full = 1'b0;
        data_from_sram = 16'hBEEF;
        sram_empty = 1'b0;
        wait_clks(10);
        sram_empty = 1'b1;
        base = wr_q.size();
        spi_xfer(16'h1111, 16, r);
        wait_clks(10);
        spi_xfer(16'hFFFF, 9, r);
        checks++;
        if (r !== 16'hBE80) begin
            failures++;
            $display("FAIL idle_partial_miso: got %h want be80", r);
        end
        wait_clks(100);
        checks++;
        if (wr_q.size() - base !== 1) begin
            failures++;
            $display("FAIL idle_nopush: got %0d want 1", wr_q.size() - base);
        end
        spi_xfer(16'h00FF, 16, r);
        checks++;
        if (r !== 16'hBEEF) begin
            failures++;
            $display("FAIL idle_represent: got %h want beef", r);
        end
        wait_clks(10);
        checks++;
        if (wr_q.size() - base !== 2) begin
            failures++;
            $display("FAIL idle_count: got %0d want 2", wr_q.size() - base);
        end else begin
            checks++;
            if (wr_q[base] !== 16'h1111 || wr_q[base+1] !== 16'h00FF) begin
                failures++;
                $display("FAIL idle_data: got %h %h want 1111 00ff",
                         wr_q[base], wr_q[base+1]);
            end
        end
        checks++;
        if (overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL idle_ovf: got %0d want 0", overflow_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        int base;
        int rd0;
        int k;
        do_reset();
        sram_hint = 1'b1;
        sram_full = 1'b0;
        sram_empty = 1'b1;
        spi_xfer(16'hFFFF, 16, r);
        wait_clks(6);
        spi_xfer(16'hFFFF, 7, r);
        sram_empty = 1'b0;
        data_from_sram = 16'h7777;
        k = 0;
        while (sram_read !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sram_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_req_seen: got %b want 1", sram_read);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sram_read !== 1'b0 || sram_write !== 1'b0 || miso !== 1'b0) begin
            failures++;
            $display("FAIL mid_strobes: got rd=%b wr=%b miso=%b want 0 0 0",
                     sram_read, sram_write, miso);
        end
        checks++;
        if (data_to_sram !== 16'h0000) begin
            failures++;
            $display("FAIL mid_data: got %h want 0000", data_to_sram);
        end
        checks++;
        if (underrun_cnt !== 8'd0 || overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_cnts: got unr=%0d ovf=%0d want 0 0",
                     underrun_cnt, overflow_cnt);
        end
        sram_empty = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        base = wr_q.size();
        rd0 = rd_cnt;
        wait_clks(20);
        checks++;
        if (wr_q.size() - base !== 0 || rd_cnt - rd0 !== 0) begin
            failures++;
            $display("FAIL mid_quiet: got wr=%0d rd=%0d want 0 0",
                     wr_q.size() - base, rd_cnt - rd0);
        end
        spi_xfer(16'h5A5A, 16, r);
        wait_clks(10);
        checks++;
        if (wr_q.size() - base !== 1) begin
            failures++;
            $display("FAIL mid_after: got %0d want 1", wr_q.size() - base);
        end else begin
            checks++;
            if (wr_q[base] !== 16'h5A5A) begin
                failures++;
                $display("FAIL mid_after_data: got %h want 5a5a", wr_q[base]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] r;
        do_reset();
        sram_hint = 1'b1;
        sram_full = 1'b1;
        sram_empty = 1'b1;
        for (int i = 0; i < 258; i++) spi_xfer(16'(i), 16, r);
        wait_clks(6);
        checks++;
        if (overflow_cnt !== 8'd254) begin
            failures++;
            $display("FAIL sat_ovf254: got %0d want 254", overflow_cnt);
        end
        spi_xfer(16'hAAAA, 16, r);
        wait_clks(6);
        checks++;
        if (overflow_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_ovf255: got %0d want 255", overflow_cnt);
        end
        for (int i = 0; i < 41; i++) spi_xfer(16'h5555, 16, r);
        wait_clks(6);
        checks++;
        if (overflow_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_ovf_hold: got %0d want 255", overflow_cnt);
        end
        checks++;
        if (underrun_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_unr: got %0d want 255", underrun_cnt);
        end
        sram_full = 1'b0;
        wait_clks(10);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_tx_prefetch();
        test_overflow();
        test_idle_abort();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
